// File: rtl/result_fifo.sv
// Show-ahead result FIFO with almost-full stall, occupancy count and sticky overflow.
// Define RESULT_FIFO_WATERMARK_EN to add the max_count high-water-mark output.
module result_fifo #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_THRESH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     stall,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  input  logic                     ovf_clr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef RESULT_FIFO_WATERMARK_EN
  ,
  output logic [$clog2(DEPTH):0]   max_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          stall_q, stall_d;
  logic          ovf_q, ovf_d;
  logic          wr_en, rd_en, drop;

  // Full is judged on the registered count, so a write into a full FIFO drops even if a read frees a slot.
  always_comb begin
    wr_en    = in_valid && !full_q;
    rd_en    = !empty_q && out_ready;
    drop     = in_valid && full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    stall_d = (count_d >= AFULL_C);
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      stall_q  <= stall_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_data;
  end

  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign stall     = stall_q;
  assign overflow  = ovf_q;
  assign out_valid = !empty_q;
  assign out_data  = empty_q ? '0 : mem[rd_ptr_q];

`ifdef RESULT_FIFO_WATERMARK_EN
  logic [CW-1:0] max_count_q, max_count_d;

  // High-water mark of post-update occupancy; ovf_clr restarts it from the new count.
  always_comb begin
    max_count_d = max_count_q;
    if (ovf_clr)                     max_count_d = count_d;
    else if (count_d > max_count_q)  max_count_d = count_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) max_count_q <= '0;
    else       max_count_q <= max_count_d;
  end

  assign max_count = max_count_q;
`endif

endmodule

// File: doc/result_fifo.md
Name: result_fifo

Overview:
- Downstream buffer for the two-stage XOR/ADD datapath stage; captures each result word presented with its valid strobe and holds it for a consumer using a valid/ready handshake.
- Generates an almost-full stall that the integrator wires to the upstream stage's enable, so results in flight are never lost.
- Show-ahead (first-word-fall-through) FIFO with occupancy count and a sticky overflow flag.

Parameters:
- WIDTH, 32, data word width; matches the upstream datapath width.
- DEPTH, 8, number of entries; power of two, minimum 4.
- AFULL_THRESH, 5, stall asserts when count >= AFULL_THRESH; must satisfy DEPTH - AFULL_THRESH >= 3 to absorb upstream pipeline slack.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result valid; a write is attempted on every cycle it is high.
- in_data  input  WIDTH  upstream result word.
- stall  output  1  high when count >= AFULL_THRESH; upstream enable = !stall.
- out_valid  output  1  head entry available (= !empty).
- out_data  output  WIDTH  head entry; all zeros when empty.
- out_ready  input  1  consumer accepts the head entry when out_valid is high.
- ovf_clr  input  1  synchronous clear of the overflow flag.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (asynchronous, active-high): rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, stall = 0, out_valid = 0, out_data = 0, overflow = 0. Storage array is not reset.
- Write: occurs when in_valid && !full. Stores in_data at wr_ptr. wr_ptr increments modulo DEPTH.
- Read: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- out_data is driven combinationally from mem[rd_ptr], gated to zero when empty.
- Latency:
  - A word written at edge N is visible on out_data with out_valid = 1 after edge N.
  - The cycle after a write into an empty FIFO shows it.
- count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
- full, empty and stall are decoded from the registered count; they are glitch-free and never combinational from the inputs.
- Simultaneous read and write:
  - Not full: both occur; count is unchanged; data order is preserved.
  - Full: full is evaluated before the read, so the write is dropped even though a slot frees that cycle. overflow is set and the read proceeds; count goes DEPTH -> DEPTH-1.
- Empty: out_ready is ignored and no pointer moves.
- Overflow:
  - in_valid && full sets overflow on that edge; the data is discarded and pointers and count are unchanged.
  - ovf_clr clears overflow. If ovf_clr and a new drop occur in the same cycle, set wins and overflow stays 1.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally; FIFO order is preserved across the wrap.
- Reset mid-operation: all contents are discarded immediately. The outputs return to their reset values without waiting for a clock edge.

Optional Feature:
- Macro: RESULT_FIFO_WATERMARK_EN.
- Defined:
  - Adds output max_count, width $clog2(DEPTH)+1, reset value 0.
  - Each edge, max_count <= max(max_count, next count), i.e. the post-update occupancy.
  - ovf_clr also clears max_count to the next count value.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 with out_ready = 0 -> count = 3, out_data = 0x11, empty = 0, stall = 0.
- Write 5 words 0xA0..0xA4 with no reads -> stall rises on the edge where count reaches 5; the next 3 writes 0xA5..0xA7 fill the FIFO (count = 8, full = 1) and overflow stays 0.
- FIFO full and in_valid = 1 with in_data = 0xDEAD while out_ready = 1 -> 0xDEAD is dropped, overflow = 1, count = 7, out_data advances to the next word. ovf_clr pulse -> overflow = 0.
- 20 continuous writes 0x00..0x13 with out_ready held at 1 -> count stays <= 1, output order is exact 0x00..0x13 across pointer wrap, and overflow = 0.
- Assert reset mid-stream with count = 4 -> out_valid = 0, out_data = 0, count = 0 and stall = 0 before the next clock edge. A write 0x55 after reset release appears at out_data the next cycle.
- With RESULT_FIFO_WATERMARK_EN: fill to 6, then drain to 0 -> max_count = 6. ovf_clr -> max_count = 0.
